subrisc_fetch: RTL

Instruction fetch front end of the SUBRISC core. Issues in-order requests to instruction memory, buffers returned words with their PC, and presents them to decode as a valid/ready stream. It drives the core-level valid/instruction pair that the simulation harness watches for the halt instruction 0x2110_4FFF. It also stops fetching on that instruction and raises a halted flag.

---
 rtl/subrisc_pkg.sv | 25 ++
 rtl/subrisc_fetch_if.sv | 41 ++++
 rtl/subrisc_fetch_buf.sv | 57 +++++
 rtl/subrisc_fetch.sv | 118 +++++++++++
 4 files changed

// File: rtl/subrisc_pkg.sv
// subrisc_pkg: shared types and constants for the SUBRISC fetch front end.
//   INSN_W      instruction word width
//   PC_W        storage width of a PC inside a buffer entry (upper bound on ADDR_W)
//   PC_STEP     PC increment per fetched word (PC counts halfwords)
//   HALT_INSN_C encoding that stops fetch
//   fetch_state_t  RUN / HALT
//   fetch_entry_t  buffered {instr, pc} pair
package subrisc_pkg;

    localparam int unsigned INSN_W      = 32;
    localparam int unsigned PC_W        = 32;
    localparam int unsigned PC_STEP     = 2;
    localparam logic [31:0] HALT_INSN_C = 32'h2110_4FFF;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSN_W-1:0] instr;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/subrisc_fetch_if.sv
// subrisc_fetch_if: handshake bundle between the fetch unit and its environment.
//   imem_req_*   request channel to instruction memory (fetch drives valid/addr)
//   imem_rsp_*   in-order response channel from instruction memory
//   redirect_*   branch/jump redirect from execute
//   id_*         valid/ready instruction stream to decode
// Modports: master = fetch unit side, slave = memory/execute/decode side.
interface subrisc_fetch_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_instr;
    logic [ADDR_W-1:0] id_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output id_valid, id_instr, id_pc,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  id_valid, id_instr, id_pc,
        output id_ready
    );

endinterface

// File: rtl/subrisc_fetch_buf.sv
// subrisc_fetch_buf: DEPTH-entry synchronous FIFO of fetch_entry_t.
//   clk, rst    clock, synchronous active-high reset
//   push        write push_entry at the tail
//   pop         drop the head entry (ignored when empty)
//   flush       empty the FIFO; takes priority over push and pop
//   count       current occupancy (0..DEPTH)
//   head        oldest entry, valid when count != 0
module subrisc_fetch_buf
    import subrisc_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    always_comb begin
        do_push = push && !flush;
        do_pop  = pop && !flush && (count != '0);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    // The request credit rule guarantees a slot for every live response.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(do_push && (count == (AW+1)'(DEPTH))));

endmodule

// File: rtl/subrisc_fetch.sv
// subrisc_fetch: instruction fetch front end of the SUBRISC core.
//   CLK, RST      clock, synchronous active-high reset
//   bus           subrisc_fetch_if.master: imem request/response, redirect,
//                 decode valid/ready stream (id_valid/id_instr/id_pc)
//   fetch_stall   decode starved: RUN state with no valid instruction
//   halted        halt instruction has been handed to decode
//   retired_cnt   number of decode handshakes, wraps modulo 2^32
module subrisc_fetch
    import subrisc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       DEPTH     = 2,
    parameter logic [31:0]       HALT_INSN = HALT_INSN_C
) (
    input  logic                 CLK,
    input  logic                 RST,
    subrisc_fetch_if.master      bus,
    output logic                 fetch_stall,
    output logic                 halted,
    output logic [31:0]          retired_cnt
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    // Stale responses are bounded by memory latency, not by DEPTH.
    localparam int unsigned SW = 8;

    fetch_state_t       state;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  rsp_pc;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      buffered;
    logic [SW-1:0]      stale;
    fetch_entry_t       head;
    fetch_entry_t       push_entry;

    logic id_hs;
    logic halt_hs;
    logic redirect_go;
    logic req_hs;
    logic rsp_live;
    logic rsp_stale;
    logic push;
    logic flush;

    always_comb begin
        bus.id_valid       = (state == RUN) && (buffered != '0);
        bus.id_instr       = head.instr;
        bus.id_pc          = head.pc[ADDR_W-1:0];
        id_hs              = bus.id_valid && bus.id_ready;
        halt_hs            = id_hs && (head.instr == HALT_INSN);
        redirect_go        = (state == RUN) && bus.redirect_valid && !halt_hs;

        bus.imem_req_valid = !RST && (state == RUN) && !bus.redirect_valid &&
                             ((32'(inflight) + 32'(buffered)) < DEPTH);
        bus.imem_req_addr  = {fetch_pc[ADDR_W-2:0], 1'b0};
        req_hs             = bus.imem_req_valid && bus.imem_req_ready;

        rsp_stale          = bus.imem_rsp_valid && (stale != '0);
        rsp_live           = bus.imem_rsp_valid && (stale == '0);
        flush              = redirect_go || halt_hs;
        push               = rsp_live && (state == RUN) && !flush;

        // Responses return in order and non-stale requests are contiguous,
        // so the PC of the next live response is a simple running counter.
        push_entry.instr   = bus.imem_rsp_data;
        push_entry.pc      = PC_W'(rsp_pc);

        fetch_stall        = (state == RUN) && !bus.id_valid;
        halted             = (state == HALT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            inflight    <= '0;
            stale       <= '0;
            retired_cnt <= '0;
        end else begin
            if (id_hs)   retired_cnt <= retired_cnt + 32'd1;
            if (halt_hs) state <= HALT;

            if (flush) begin
                // Everything still outstanding at memory becomes stale,
                // including a request accepted this cycle and minus a live
                // response that is being discarded right now.
                inflight <= '0;
                stale    <= stale - SW'(rsp_stale) + SW'(inflight)
                          + SW'(req_hs) - SW'(rsp_live);
                if (redirect_go) begin
                    fetch_pc <= bus.redirect_pc;
                    rsp_pc   <= bus.redirect_pc;
                end
            end else begin
                inflight <= inflight + CW'(req_hs) - CW'(rsp_live);
                stale    <= stale - SW'(rsp_stale);
                if (req_hs) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
                if (push)   rsp_pc   <= rsp_pc + ADDR_W'(PC_STEP);
            end
        end
    end

    subrisc_fetch_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (CLK),
        .rst        (RST),
        .push       (push),
        .push_entry (push_entry),
        .pop        (id_hs),
        .flush      (flush),
        .count      (buffered),
        .head       (head)
    );

endmodule
